// File: rtl/intctl_pkg.sv
// intctl_pkg: shared constants and types for the interrupt controller.
//   - register offsets on adr_i (CPU address [3:2])
//   - source bit positions in irq_i
//   - per-source interrupt code table used by the priority encoder
//   - src_vec_t, the 7-bit per-source vector type
package intctl_pkg;

  localparam int NSRC_DEF = 7;

  typedef logic [6:0] src_vec_t;

  // Register offsets
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_CODE    = 2'd3;

  // Source bit positions in irq_i
  localparam int SRC_UART0_TX = 0;
  localparam int SRC_UART0_RX = 1;
  localparam int SRC_TIMER0   = 2;
  localparam int SRC_TIMER1   = 3;
  localparam int SRC_TIMER2   = 4;
  localparam int SRC_TIMER3   = 5;
  localparam int SRC_MMU      = 6;

  localparam logic [3:0] CODE_NONE = 4'd0;

  // Code delivered to the CPU per source, indexed by source number.
  // The codes are not monotonic in priority: the CPU's vector table
  // predates this block, so uart lines keep codes 6/7 and MMU keeps 1.
  localparam logic [6:0][3:0] SRC_CODE = {
    4'd1,  // src6 MMU fault
    4'd5,  // src5 timer3
    4'd4,  // src4 timer2
    4'd3,  // src3 timer1
    4'd2,  // src2 timer0
    4'd6,  // src1 uart0 rx
    4'd7   // src0 uart0 tx
  };

endpackage

// File: rtl/intctl_if.sv
// intctl_if: Wishbone classic bus bundle between the CPU I/O decoder
// (master) and the interrupt controller register file (slave).
//   adr_i  [1:0]  register select (CPU address [3:2])
//   dat_i  [31:0] write data
//   dat_o  [31:0] read data (registered in the slave)
//   we_i          write enable
//   sel_i  [3:0]  byte selects, only bit 0 is honoured by the slave
//   stb_i         strobe
//   cyc_i         bus cycle
//   ack_o         one-cycle acknowledge
interface intctl_if;

  logic [1:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;

  modport master (
    output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
    output dat_o, ack_o
  );

endinterface

// File: rtl/intctl_prienc.sv
// intctl_prienc: purely combinational 7-to-4 priority encoder.
// Picks the highest-priority active source (src6 highest, src0 lowest)
// and emits its code from intctl_pkg::SRC_CODE; no active source -> 0.
//   active [6:0]  masked and gated source vector
//   code   [3:0]  interrupt code for the winning source
module intctl_prienc
  import intctl_pkg::*;
(
  input  src_vec_t   active,
  output logic [3:0] code
);

  // Fixed priority chain, MMU fault first, uart0 tx last
  always_comb begin
    code = CODE_NONE;
    if (active[SRC_MMU]) begin
      code = SRC_CODE[SRC_MMU];
    end else if (active[SRC_TIMER3]) begin
      code = SRC_CODE[SRC_TIMER3];
    end else if (active[SRC_TIMER2]) begin
      code = SRC_CODE[SRC_TIMER2];
    end else if (active[SRC_TIMER1]) begin
      code = SRC_CODE[SRC_TIMER1];
    end else if (active[SRC_TIMER0]) begin
      code = SRC_CODE[SRC_TIMER0];
    end else if (active[SRC_UART0_RX]) begin
      code = SRC_CODE[SRC_UART0_RX];
    end else if (active[SRC_UART0_TX]) begin
      code = SRC_CODE[SRC_UART0_TX];
    end else begin
      code = CODE_NONE;
    end
  end

endmodule

// File: rtl/intctl.sv
// intctl: registered interrupt controller, Wishbone classic slave.
// Captures seven interrupt sources (edge or level per source), masks
// them, gates them with the CPU global enable and drives a registered
// 4-bit interrupt code to the CPU.
//
// Registers (adr_i), bits [31:7] read 0 and ignore writes:
//   0 PENDING  read, write-1-to-clear (edge-mode sources only)
//   1 MASK     read/write, 1 enables the source
//   2 MODE     read/write, 1 = edge, 0 = level
//   3 CODE     read-only, current interrupt_o in bits [3:0]
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   bus          intctl_if.slave Wishbone bundle
//   irq_i  [6:0] sources, synchronous to clk_i (6 MMU, 5..2 timers,
//                1 uart0 rx, 0 uart0 tx)
//   int_en       CPU global interrupt enable
//   interrupt_o  registered interrupt code, 0 = none
//
// Build option: define INTCTL_NMI_EN to make the MMU fault (src6)
// non-maskable: it bypasses MASK and int_en, and MASK bit 6 reads 1.
module intctl
  import intctl_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  intctl_if.slave    bus,
  input  src_vec_t   irq_i,
  input  logic       int_en,
  output logic [3:0] interrupt_o
);

  localparam int PAD_W = 32 - NSRC;

  logic        ack_r;
  logic [31:0] dat_r;
  src_vec_t    pending_r;
  src_vec_t    mask_r;
  src_vec_t    mode_r;
  src_vec_t    prev_r;
  logic [3:0]  code_r;

  logic        access_s;
  logic        wr_s;
  logic        wr_pending_s;
  logic        wr_mask_s;
  logic        wr_mode_s;
  src_vec_t    wdata_s;
  src_vec_t    clr_s;
  src_vec_t    edge_set_s;
  src_vec_t    pending_nxt_s;
  src_vec_t    mask_wr_s;
  src_vec_t    mask_rd_s;
  src_vec_t    active_s;
  src_vec_t    rd_s;
  logic [3:0]  enc_s;
  logic        unused_s;

  assign bus.ack_o   = ack_r;
  assign bus.dat_o   = dat_r;
  assign interrupt_o = code_r;

  // Upper data bits and upper byte selects carry nothing for this block
  assign unused_s = ^{bus.dat_i[31:7], bus.sel_i[3:1]};

  // Decode the access acknowledged on the coming edge; writes happen only there
  always_comb begin
    access_s     = bus.stb_i & bus.cyc_i & ~ack_r;
    wr_s         = access_s & bus.we_i & bus.sel_i[0];
    wdata_s      = bus.dat_i[6:0];
    wr_pending_s = 1'b0;
    wr_mask_s    = 1'b0;
    wr_mode_s    = 1'b0;
    if (wr_s) begin
      case (bus.adr_i)
        REG_PENDING: wr_pending_s = 1'b1;
        REG_MASK:    wr_mask_s    = 1'b1;
        REG_MODE:    wr_mode_s    = 1'b1;
        default: begin
          // CODE is read-only
          wr_pending_s = 1'b0;
          wr_mask_s    = 1'b0;
          wr_mode_s    = 1'b0;
        end
      endcase
    end else begin
      wr_pending_s = 1'b0;
      wr_mask_s    = 1'b0;
      wr_mode_s    = 1'b0;
    end
  end

  // Pending next state: level bits copy irq_i, edge bits latch rising edges
  // and clear on W1C; a new edge in the same cycle as a clear wins.
  always_comb begin
    edge_set_s = irq_i & ~prev_r;
    if (wr_pending_s) begin
      clr_s = wdata_s;
    end else begin
      clr_s = 7'h00;
    end
    pending_nxt_s = (mode_r & ((pending_r & ~clr_s) | edge_set_s))
                  | (~mode_r & irq_i);
  end

  // Mask views and active vector; NMI build hard-wires src6 as enabled
  always_comb begin
`ifdef INTCTL_NMI_EN
    mask_wr_s = {1'b0, wdata_s[5:0]};
    mask_rd_s = mask_r | 7'h40;
    active_s  = ({1'b0, pending_r[5:0] & mask_r[5:0]} & {7{int_en}})
              | {pending_r[6], 6'h00};
`else
    mask_wr_s = wdata_s;
    mask_rd_s = mask_r;
    active_s  = pending_r & mask_r & {7{int_en}};
`endif
  end

  // Register read mux, sampled into dat_o together with the ack
  always_comb begin
    case (bus.adr_i)
      REG_PENDING: rd_s = pending_r;
      REG_MASK:    rd_s = mask_rd_s;
      REG_MODE:    rd_s = mode_r;
      REG_CODE:    rd_s = {3'b000, code_r};
      default:     rd_s = 7'h00;
    endcase
  end

  intctl_prienc u_prienc (
    .active (active_s),
    .code   (enc_s)
  );

  // Bus handshake: one-cycle ack per access, read data captured with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= access_s;
      if (access_s) begin
        // Pre-write value: rd_s reflects registers before this edge
        dat_r <= {{PAD_W{1'b0}}, rd_s};
      end
    end
  end

  // Source capture and configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_r <= 7'h00;
      mask_r    <= 7'h00;
      mode_r    <= 7'h00;
      prev_r    <= 7'h00;
    end else begin
      pending_r <= pending_nxt_s;
      prev_r    <= irq_i;
      if (wr_mask_s) begin
        mask_r <= mask_wr_s;
      end
      if (wr_mode_s) begin
        mode_r <= wdata_s;
      end
    end
  end

  // Registered interrupt code towards the CPU
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      code_r <= 4'd0;
    end else begin
      code_r <= enc_s;
    end
  end

endmodule
